// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, with the quotient and remainder signs fixed up in a final cycle.
module seq_signed_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] x,
  input  logic [VW-1:0] y,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dbz,
  output logic          ovf
);
  // state | meaning
  // IDLE  | waiting for start; result outputs hold the last result
  // CALC  | one restoring-division step per clock, DW steps in total
  // SIGN  | apply operand signs to the magnitudes, pulse done
  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  localparam int CW = $clog2(DW);

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic          sx_q, sx_d;
  logic          sy_q, sy_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Partial remainder after the left shift; one bit wider than rem so that
  // 2*rem+1 never overflows before the trial subtraction.
  logic [VW:0]   shifted;
  logic          trial_ge;

  always_comb begin
    shifted  = {rem_q, dvd_q[DW-1]};
    trial_ge = (shifted >= {1'b0, dvs_q});

    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    q_d        = q_q;
    r_d        = r_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    ovf_pend_d = ovf_pend_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sx_d = x[DW-1];
          sy_d = y[VW-1];
          if (y == '0) begin
            q_d    = '0;
            r_d    = '0;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            // Magnitude of the most-negative value is read as unsigned, so it fits.
            dvd_d      = x[DW-1] ? -x : x;
            dvs_d      = y[VW-1] ? -y : y;
            rem_d      = '0;
            cnt_d      = '0;
            ovf_pend_d = (x == {1'b1, {(DW-1){1'b0}}}) && (y == '1);
            busy_d     = 1'b1;
            state_d    = CALC;
          end
        end
      end

      CALC: begin
        if (trial_ge) begin
          rem_d = VW'(shifted - {1'b0, dvs_q});
          dvd_d = {dvd_q[DW-2:0], 1'b1};
        end else begin
          rem_d = shifted[VW-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) state_d = SIGN;
      end

      SIGN: begin
        q_d     = (sx_q ^ sy_q) ? -dvd_q : dvd_q;
        r_d     = sx_q ? -rem_q : rem_q;
        ovf_d   = ovf_pend_q;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      ovf_pend_q <= ovf_pend_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Iterative two's-complement divider that inverts the signed 8x8 array multiplier: given a 16-bit signed product-width dividend and an 8-bit signed divisor, it returns quotient and remainder such that dividend = quotient*divisor + remainder.
- Restoring algorithm on magnitudes, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath.

Parameters:
- DW, 16, dividend and quotient width (iteration count = DW)
- VW, 8, divisor and remainder width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- x  input  DW  signed dividend
- y  input  VW  signed divisor
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; q, r and the flags are valid from this cycle
- q  output  DW  signed quotient
- r  output  VW  signed remainder
- dbz  output  1  divide-by-zero flag for the last result
- ovf  output  1  quotient-overflow flag for the last result

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset: state=IDLE; busy, done, q, r, dbz and ovf are all 0. A reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, SIGN.
- IDLE, start=1 at edge N:
  - Capture sx=x[DW-1] and sy=y[VW-1].
  - Load |x| into a DW-bit unsigned dividend shift register and |y| into a VW-bit register.
  - Clear the (VW+1)-bit partial remainder and the iteration counter.
  - busy<=1; go to CALC.
- Divide by zero: if y==0 at the start edge, skip CALC. At edge N: q<=0, r<=0, dbz<=1, ovf<=0, done<=1, busy stays 0, stay in IDLE.
- CALC (edges N+1..N+DW), per cycle:
  - Shift {rem, dividend} left by 1.
  - trial = rem - |y|.
  - If trial >= 0: rem<=trial and quotient LSB<=1; else quotient LSB<=0.
  - After DW iterations go to SIGN.
- SIGN (edge N+DW+1):
  - q <= (sx^sy) ? -qmag : qmag, truncated to DW bits.
  - r <= sx ? -rmag : rmag, truncated to VW bits.
  - ovf <= 1 only when x = most-negative value and y = -1 (q wraps to 16'h8000); dbz<=0.
  - done<=1, busy<=0, go to IDLE.
- Latency: done is high in the cycle after edge N+DW+1, i.e. 17 clocks after the start edge at default widths. The divide-by-zero path takes 1 clock.
- done is high for exactly one cycle. q, r, dbz and ovf hold until the next done.
- Result semantics: truncation toward zero; the remainder takes the dividend's sign; |r| < |y|. Since |y| <= 128, |r| <= 127 always fits in VW signed bits.
- Magnitudes: |most-negative| is taken unsigned (e.g. 16'h8000 gives 32768 in DW bits, 8'h80 gives 128 in VW bits), so no extra width is needed.
- start while busy=1 is ignored and the operands are not re-captured.
- start during the done cycle (state IDLE) is accepted, giving back-to-back operation.
- x and y are sampled only on the start edge; later changes have no effect.

Test Plan:
- x=1000, y=7, start one cycle -> busy for 17 cycles, done pulse, q=142, r=6, dbz=0, ovf=0.
- Sign matrix:
  - x=16'hFC18 (-1000), y=7 -> q=16'hFF72, r=8'hFA.
  - x=1000, y=8'hF9 (-7) -> q=16'hFF72, r=6.
  - x=-1000, y=-7 -> q=142, r=8'hFA.
- Extremes:
  - x=16'h8000, y=8'hFF -> q=16'h8000, r=0, ovf=1.
  - x=16'h8000, y=8'h80 -> q=256, r=0, ovf=0.
  - x=16'h7FFF, y=1 -> q=16'h7FFF.
- y=0, x=1234 -> done one cycle after start, busy never asserted, dbz=1, q=0, r=0. The next valid division clears dbz.
- start re-pulsed with new operands at cycle 5 of a division -> ignored, original result returned. start held high during the done cycle -> second division begins immediately and its done arrives 17 cycles later.
- rst=1 at cycle 8 of a division -> next cycle busy=0, done=0, q=0, r=0, no done pulse. A subsequent start runs normally.
